lab3_dg_digit_store: RTL and testbench

Downstream consumer of the keypad scanner FSM. On each debounced key strobe it decodes the scanner's {cols, rows} keypress code to a hex digit. It shifts that digit into a two-entry history (newest/oldest). It then time-multiplexes both digits onto a dual common-anode seven-segment display, with an anode dead-time to suppress ghosting.

---
 rtl/lab3_dg_digit_store.sv | 145 ++++++++++++++
 tb/tb_lab3_dg_digit_store.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/lab3_dg_digit_store.sv
// Keypad digit store: decodes scanner strobes into a two-digit history and
// time-multiplexes both digits onto a dual common-anode seven-segment display.
module lab3_dg_digit_store #(
    parameter int MUX_DIV      = 24000,
    parameter int BLANK_CYCLES = 480
) (
    input  logic       int_osc,
    input  logic       reset,
    input  logic [7:0] keypress,
    input  logic       alarm,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old,
    output logic       bad_key
);
    localparam int CW = (MUX_DIV > 2) ? $clog2(MUX_DIV) : 2;
    localparam logic [CW-1:0] CNT_MAX = CW'(MUX_DIV - 1);
    localparam logic [CW-1:0] BLANK_C = CW'(BLANK_CYCLES);

    logic [3:0]    r_digit_new, r_digit_old;
    logic          r_valid_new, r_valid_old;
    logic [CW-1:0] r_cnt;
    logic          r_sel;
    logic          r_bad;
    logic [6:0]    r_seg;
    logic [1:0]    r_an;

    logic [1:0] w_c, w_r;
    logic       w_cok, w_rok, w_legal;
    logic [3:0] w_digit;
    logic       w_show;
    logic [3:0] w_shown_digit;
    logic [6:0] w_glyph;

    // Column/row fields are active-low one-hot; anything else is illegal.
    always_comb begin
        w_c   = 2'd0;
        w_cok = 1'b1;
        case (keypress[7:4])
            4'b1110: w_c = 2'd0;
            4'b1101: w_c = 2'd1;
            4'b1011: w_c = 2'd2;
            4'b0111: w_c = 2'd3;
            default: w_cok = 1'b0;
        endcase
        w_r   = 2'd0;
        w_rok = 1'b1;
        case (keypress[3:0])
            4'b1110: w_r = 2'd0;
            4'b1101: w_r = 2'd1;
            4'b1011: w_r = 2'd2;
            4'b0111: w_r = 2'd3;
            default: w_rok = 1'b0;
        endcase
        w_legal = w_cok & w_rok;
    end

    always_comb begin
        case ({w_r, w_c})
            4'h0: w_digit = 4'h1;
            4'h1: w_digit = 4'h2;
            4'h2: w_digit = 4'h3;
            4'h3: w_digit = 4'hA;
            4'h4: w_digit = 4'h4;
            4'h5: w_digit = 4'h5;
            4'h6: w_digit = 4'h6;
            4'h7: w_digit = 4'hB;
            4'h8: w_digit = 4'h7;
            4'h9: w_digit = 4'h8;
            4'hA: w_digit = 4'h9;
            4'hB: w_digit = 4'hC;
            4'hC: w_digit = 4'hE;
            4'hD: w_digit = 4'h0;
            4'hE: w_digit = 4'hF;
            default: w_digit = 4'hD;
        endcase
    end

    // A slot only lights after its dead-time and only if its digit has been entered.
    always_comb begin
        w_show        = (r_cnt >= BLANK_C) && (r_sel ? r_valid_old : r_valid_new);
        w_shown_digit = r_sel ? r_digit_old : r_digit_new;
        case (w_shown_digit)
            4'h0: w_glyph = 7'b1000000;
            4'h1: w_glyph = 7'b1111001;
            4'h2: w_glyph = 7'b0100100;
            4'h3: w_glyph = 7'b0110000;
            4'h4: w_glyph = 7'b0011001;
            4'h5: w_glyph = 7'b0010010;
            4'h6: w_glyph = 7'b0000010;
            4'h7: w_glyph = 7'b1111000;
            4'h8: w_glyph = 7'b0000000;
            4'h9: w_glyph = 7'b0010000;
            4'hA: w_glyph = 7'b0001000;
            4'hB: w_glyph = 7'b0000011;
            4'hC: w_glyph = 7'b1000110;
            4'hD: w_glyph = 7'b0100001;
            4'hE: w_glyph = 7'b0000110;
            default: w_glyph = 7'b0001110;
        endcase
    end

    always_ff @(posedge int_osc) begin
        if (reset) begin
            r_digit_new <= 4'd0;
            r_digit_old <= 4'd0;
            r_valid_new <= 1'b0;
            r_valid_old <= 1'b0;
            r_bad       <= 1'b0;
        end else begin
            r_bad <= alarm & ~w_legal;
            if (alarm && w_legal) begin
                r_digit_old <= r_digit_new;
                r_valid_old <= r_valid_new;
                r_digit_new <= w_digit;
                r_valid_new <= 1'b1;
            end
        end
    end

    always_ff @(posedge int_osc) begin
        if (reset) begin
            r_cnt <= '0;
            r_sel <= 1'b0;
            r_seg <= 7'b1111111;
            r_an  <= 2'b11;
        end else begin
            if (r_cnt == CNT_MAX) begin
                r_cnt <= '0;
                r_sel <= ~r_sel;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            r_an  <= w_show ? (r_sel ? 2'b01 : 2'b10) : 2'b11;
            r_seg <= w_show ? w_glyph : 7'b1111111;
        end
    end

    assign seg       = r_seg;
    assign an        = r_an;
    assign digit_new = r_digit_new;
    assign digit_old = r_digit_old;
    assign bad_key   = r_bad;
endmodule

// File: tb/tb_lab3_dg_digit_store.sv
// Bench for lab3_dg_digit_store: directed vector table plus randomized strobes,
// with a cycle-level reference model checking display and history every cycle.
module tb_lab3_dg_digit_store;
    localparam int M = 20;
    localparam int B = 4;

    logic       int_osc = 1'b0;
    logic       reset   = 1'b1;
    logic [7:0] keypress = 8'hFF;
    logic       alarm   = 1'b0;
    logic [6:0] seg;
    logic [1:0] an;
    logic [3:0] digit_new, digit_old;
    logic       bad_key;

    int total = 0;
    int bad   = 0;

    lab3_dg_digit_store #(.MUX_DIV(M), .BLANK_CYCLES(B)) dut (
        .int_osc(int_osc), .reset(reset), .keypress(keypress), .alarm(alarm),
        .seg(seg), .an(an), .digit_new(digit_new), .digit_old(digit_old),
        .bad_key(bad_key)
    );

    always #5 int_osc = ~int_osc;

    // Key layout by row then column; glyphs as active-high {g..a}.
    int KEYS [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
    logic [6:0] HI [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic int zero_idx(input logic [3:0] f);
        int n = 0, idx = -1;
        for (int i = 0; i < 4; i++) if (f[i] == 1'b0) begin n++; idx = i; end
        return (n == 1) ? idx : -1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: history as plain values, display phase from cycles since reset.
    int  m_new = 0, m_old = 0, m_j = 0, p_j = 0;
    bit  m_vn = 0, m_vo = 0, m_bad = 0, m_init = 0, m_rst = 0;
    int  p_new = 0, p_old = 0;
    bit  p_vn = 0, p_vo = 0;

    always @(posedge int_osc) begin
        int c, r;
        p_new = m_new; p_old = m_old; p_vn = m_vn; p_vo = m_vo; p_j = m_j;
        if (reset) begin
            m_new = 0; m_old = 0; m_vn = 0; m_vo = 0; m_bad = 0; m_j = 0;
            m_rst = 1; m_init = 1;
        end else begin
            m_rst = 0;
            m_j++;
            c = zero_idx(keypress[7:4]);
            r = zero_idx(keypress[3:0]);
            m_bad = alarm && (c < 0 || r < 0);
            if (alarm && c >= 0 && r >= 0) begin
                m_old = m_new; m_vo = m_vn;
                m_new = KEYS[r*4 + c]; m_vn = 1;
            end
        end
    end

    always begin
        int cnt, sl, ean, eseg;
        @(posedge int_osc);
        #1;
        if (m_init) begin
            ean = 3; eseg = 7'h7F;
            if (!m_rst) begin
                cnt = p_j % M;
                sl  = (p_j / M) % 2;
                if (cnt >= B) begin
                    if (sl == 0 && p_vn) begin ean = 2; eseg = {25'd0, ~HI[p_new]}; end
                    if (sl == 1 && p_vo) begin ean = 1; eseg = {25'd0, ~HI[p_old]}; end
                end
            end
            chk("mon_an", int'(an), ean);
            chk("mon_seg", int'(seg), eseg);
            chk("mon_new", int'(digit_new), m_new);
            chk("mon_old", int'(digit_old), m_old);
            chk("mon_bad", int'(bad_key), int'(m_bad));
        end
    end

    typedef struct {
        bit         rst;
        bit         al;
        logic [7:0] kp;
        logic [3:0] e_new;
        logic [3:0] e_old;
        bit         e_bad;
    } vec_t;

    task automatic drive(input bit r, input bit a, input logic [7:0] k);
        @(negedge int_osc);
        reset = r; alarm = a; keypress = k;
        @(posedge int_osc);
        #1;
    endtask

    vec_t vt [16];

    initial begin
        logic [3:0] h_new, h_old;
        vt[0]  = '{1, 1, 8'b1011_1101, 4'h0, 4'h0, 0};
        vt[1]  = '{0, 0, 8'b0000_1110, 4'h0, 4'h0, 0};
        vt[2]  = '{0, 1, 8'b1110_1110, 4'h1, 4'h0, 0};
        vt[3]  = '{0, 0, 8'b0000_0000, 4'h1, 4'h0, 0};
        vt[4]  = '{0, 1, 8'b1101_0111, 4'h0, 4'h1, 0};
        vt[5]  = '{0, 1, 8'b0111_1011, 4'hC, 4'h0, 0};
        vt[6]  = '{0, 1, 8'b1100_1110, 4'hC, 4'h0, 1};
        vt[7]  = '{0, 0, 8'b1110_1110, 4'hC, 4'h0, 0};
        vt[8]  = '{0, 1, 8'b0000_0111, 4'hC, 4'h0, 1};
        vt[9]  = '{0, 1, 8'b1101_1101, 4'h5, 4'hC, 0};
        vt[10] = '{0, 1, 8'b1011_1011, 4'h9, 4'h5, 0};
        vt[11] = '{0, 1, 8'b0000_0000, 4'h9, 4'h5, 1};
        vt[12] = '{0, 1, 8'b1111_1111, 4'h9, 4'h5, 1};
        vt[13] = '{0, 0, 8'b1111_1111, 4'h9, 4'h5, 0};
        vt[14] = '{0, 1, 8'b1110_0111, 4'hE, 4'h9, 0};
        vt[15] = '{0, 1, 8'b0111_1110, 4'hA, 4'hE, 0};

        // Reset, then idle for three slots: display must stay dark.
        drive(1, 0, 8'hFF);
        chk("rst_an", int'(an), 3);
        chk("rst_seg", int'(seg), 7'h7F);
        chk("rst_new", int'(digit_new), 0);
        chk("rst_bad", int'(bad_key), 0);
        for (int i = 0; i < 3*M; i++) drive(0, 0, 8'hFF);
        chk("idle_new", int'(digit_new), 0);
        chk("idle_old", int'(digit_old), 0);

        // Single digit 1 then let it display through both slot types.
        drive(0, 1, 8'b1110_1110);
        chk("one_new", int'(digit_new), 1);
        chk("one_old", int'(digit_old), 0);
        for (int i = 0; i < 2*M; i++) drive(0, 0, 8'hFF);

        foreach (vt[i]) begin
            drive(vt[i].rst, vt[i].al, vt[i].kp);
            chk($sformatf("vec%0d_new", i), int'(digit_new), int'(vt[i].e_new));
            chk($sformatf("vec%0d_old", i), int'(digit_old), int'(vt[i].e_old));
            chk($sformatf("vec%0d_bad", i), int'(bad_key), int'(vt[i].e_bad));
        end

        // Scanner hold code with no strobe for 100 cycles leaves history alone.
        h_new = digit_new; h_old = digit_old;
        for (int i = 0; i < 100; i++) begin
            drive(0, 0, 8'b0000_1110);
            chk("hold_bad", int'(bad_key), 0);
        end
        chk("hold_new", int'(digit_new), int'(vt[15].e_new));
        chk("hold_old", int'(digit_old), int'(vt[15].e_old));

        // Randomized strobes; the model monitor checks every cycle.
        for (int i = 0; i < 1500; i++) begin
            logic [7:0] k;
            bit a, r;
            if ($urandom_range(0, 1) == 1)
                k = {~(4'b0001 << $urandom_range(0, 3)), ~(4'b0001 << $urandom_range(0, 3))};
            else
                k = 8'($urandom);
            a = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 299) == 0);
            drive(r, a, k);
        end
        drive(0, 0, 8'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
